// File: rtl/pal_serial.sv
// Parallel-to-serial converter: DEPTH-entry input FIFO feeding a WIDTH-bit shifter.
// Optional even-parity trailer bit per frame when PAL_SERIAL_PARITY_EN is defined.
module pal_serial #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             en,
  output logic             busy,
  output logic             word_done
);

`ifdef PAL_SERIAL_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CW   = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(FRAME - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] ONE_CNT  = CNTW'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNTW-1:0]  count;
  logic             push, pop;
  logic [WIDTH-1:0] head;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt, cnt_next;
`ifdef PAL_SERIAL_PARITY_EN
  logic             parity;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  // A pop only ever happens to load the shifter: from IDLE, or back-to-back on the last frame bit.
  always_comb begin
    din_ready = (count != FULL_CNT);
    push      = din_valid && din_ready;
    pop       = (count != '0) && ((state == IDLE) || (bit_cnt == LAST_CNT));
    head      = mem[rd_ptr];
    cnt_next  = bit_cnt + CW'(1);
    busy      = (state != IDLE) || (count != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      out       <= 1'b0;
      en        <= 1'b0;
      word_done <= 1'b0;
`ifdef PAL_SERIAL_PARITY_EN
      parity    <= 1'b0;
`endif
    end else if (pop) begin
      state     <= SHIFT;
      shreg     <= head;
      bit_cnt   <= '0;
      out       <= first_bit(head);
      en        <= 1'b1;
      word_done <= (LAST_CNT == '0);
`ifdef PAL_SERIAL_PARITY_EN
      parity    <= ^head;
`endif
    end else if (state == SHIFT && bit_cnt != LAST_CNT) begin
      bit_cnt   <= cnt_next;
      shreg     <= advance(shreg);
      en        <= 1'b1;
      word_done <= (cnt_next == LAST_CNT);
`ifdef PAL_SERIAL_PARITY_EN
      if (bit_cnt == CW'(WIDTH - 1))
        out <= parity;
      else
        out <= first_bit(advance(shreg));
`else
      out       <= first_bit(advance(shreg));
`endif
    end else begin
      state     <= IDLE;
      bit_cnt   <= '0;
      out       <= 1'b0;
      en        <= 1'b0;
      word_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pal_serial.sv
// Bench for pal_serial: table-driven words plus hand sequences, serial bits checked
// against a queue of expected bits filled at each accepted handshake.
module tb_pal_serial;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 2;
`ifdef PAL_SERIAL_PARITY_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready, out, en, busy, word_done;

  pal_serial #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .out(out), .en(en), .busy(busy), .word_done(word_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] word;
    logic [3:0] stream;  // expected bits on out, stream[3] first
    logic       par;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_q[$];
  int   frame_pos = 0;
  logic ready_low_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_expected(input logic [3:0] s, input logic p);
    for (int i = 3; i >= 0; i--) exp_q.push_back(s[i]);
`ifdef PAL_SERIAL_PARITY_EN
    exp_q.push_back(p);
`else
    if (p === 1'bx) exp_q.push_back(1'b0);
`endif
  endtask

  // Hold the word until the handshake completes; leaves din_valid high for the caller.
  task automatic send(input logic [3:0] w, input logic [3:0] s, input logic p);
    int c = 0;
    bit ok = 1'b1;
    din = w;
    din_valid = 1'b1;
    @(posedge clk);
    while (!din_ready) begin
      ready_low_seen = 1'b1;
      c++;
      if (c > 50) begin
        check("accept_timeout", 0, 1);
        ok = 1'b0;
        break;
      end
      @(posedge clk);
    end
    if (ok) push_expected(s, p);
    #1;
  endtask

  task automatic measure_en(output int lat, output int len);
    lat = 0;
    len = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!en && lat < 30);
    if (!en) check("en_timeout", 0, 1);
    while (en && len < 40) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((busy || exp_q.size() != 0) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", busy, 0);
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check("rst_out", out, 0);
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", word_done, 0);
    check("rst_ready", din_ready, 1);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      frame_pos = 0;
    end else if (en) begin
      if (exp_q.size() == 0) check("unexpected_bit", 1, 0);
      else check("serial_bit", out, exp_q.pop_front());
      check("word_done", word_done, frame_pos == FRAME - 1);
      frame_pos = (frame_pos == FRAME - 1) ? 0 : frame_pos + 1;
    end else begin
      check("idle_out", out, 0);
      check("idle_done", word_done, 0);
      check("frame_gap", frame_pos, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int lat, len, cnt;
    logic [3:0] w;

    tbl[0] = '{4'b1011, 4'b1011, 1'b1};
    tbl[1] = '{4'b0000, 4'b0000, 1'b0};
    tbl[2] = '{4'b1111, 4'b1111, 1'b0};
    tbl[3] = '{4'b1000, 4'b1000, 1'b1};
    tbl[4] = '{4'b0001, 4'b0001, 1'b1};
    tbl[5] = '{4'b0110, 4'b0110, 1'b0};
    tbl[6] = '{4'b0111, 4'b0111, 1'b1};

    reset = 1'b1;
    din = '0;
    din_valid = 1'b0;
    #1  check_reset_vals();
    #29 check_reset_vals();
    #24 check_reset_vals();
    #3  reset = 1'b0;
    @(posedge clk);
    #1;

    // single word: latency, frame length, word_done position
    send(4'b1011, 4'b1011, 1'b1);
    din_valid = 1'b0;
    measure_en(lat, len);
    check("first_bit_latency", lat, 2);
    check("single_frame_len", len, FRAME);
    wait_idle();

    // back-to-back words: no gap in en
    send(4'b1011, 4'b1011, 1'b1);
    send(4'b0110, 4'b0110, 1'b0);
    din_valid = 1'b0;
    measure_en(lat, len);
    check("b2b_en_run", len, 2 * FRAME);
    wait_idle();

    // streaming into a full FIFO
    ready_low_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w = 4'(i);
      send(w, w, ^w);
    end
    din_valid = 1'b0;
    check("ready_dropped", ready_low_seen, 1);
    wait_idle();

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].word, tbl[i].stream, tbl[i].par);
      din_valid = 1'b0;
      if (i % 2 == 1) wait_idle();
    end
    wait_idle();

`ifdef PAL_SERIAL_PARITY_EN
    send(4'b0111, 4'b0111, 1'b1);
    din_valid = 1'b0;
    measure_en(lat, len);
    check("parity_frame_len", len, 5);
    wait_idle();
`endif

    // reset mid-frame with one word queued
    send(4'b1100, 4'b1100, 1'b0);
    send(4'b1010, 4'b1010, 1'b0);
    din_valid = 1'b0;
    cnt = 0;
    while (!en && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    check("mid_busy_before", busy, 1);
    #2 reset = 1'b1;
    #1 check_reset_vals();
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (en) cnt++;
    end
    check("post_reset_silent", cnt, 0);
    check("post_reset_busy", busy, 0);
    send(4'b0101, 4'b0101, 1'b0);
    din_valid = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
